// File: rtl/mul_div_32_if.sv
// ---------------------------------------------------------------------------
// mul_div_32_if
// Handshake and result bundle for the iterative multiply/divide unit.
//   start        request, sampled only while the unit is idle
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands
//   busy         operation in progress (processor stalls)
//   done         one-cycle pulse when hi/lo have been updated
//   div_by_zero  last DIV/DIVU had b==0
//   hi, lo       architectural HI / LO registers
// With MDU_HILO_WRITE_EN defined the bundle also carries hi_we, lo_we and
// wdata for MTHI / MTLO.
// master: the requester (pipeline / testbench); slave: the unit itself.
// ---------------------------------------------------------------------------
interface mul_div_32_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_HILO_WRITE_EN
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
`else
  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
`endif
endinterface

// File: rtl/mul_div_32.sv
// ---------------------------------------------------------------------------
// mul_div_32
// Iterative radix-2 multiply/divide unit holding HI/LO. MULT/MULTU use a
// shift-add on {acc, mplier}; DIV/DIVU use restoring shift-subtract. All
// add/subtract work shares the single add_32 instance. Fixed latency: 32
// iterations plus one sign-fix cycle.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   mdu    mul_div_32_if.slave (start/op/a/b in; busy/done/div_by_zero/hi/lo out)
// Optional feature macro: MDU_HILO_WRITE_EN adds MTHI/MTLO writes through
// mdu.hi_we / mdu.lo_we / mdu.wdata, honoured only while idle.
//
// state  | meaning
// S_IDLE | waiting for start; hi/lo hold
// S_CALC | one multiply/divide iteration per clock, count 0..ITER-1
// S_FIX  | sign fix, hi/lo write, done pulse follows
// ---------------------------------------------------------------------------
module add_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ci_i,
  output logic [31:0] sum_o,
  output logic        co_o
);
  assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, ci_i};
endmodule

module mul_div_32 #(
  parameter int ITER = 32
) (
  input logic         clk,
  input logic         rst_n,
  mul_div_32_if.slave mdu
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic        zdiv_q, zdiv_d;
  logic        dbz_q, dbz_d;
  logic        done_q, done_d;
  logic [31:0] acc_q, acc_d;     // product high half / partial remainder
  logic [31:0] mq_q, mq_d;       // multiplier / dividend-then-quotient
  logic [31:0] mcand_q, mcand_d; // multiplicand / divisor magnitude
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_ci, add_co;

  logic        sgn, sa, sb, ok;
  logic [31:0] mag_a, mag_b;

  add_32 u_add (
    .a_i   (add_a),
    .b_i   (add_b),
    .ci_i  (add_ci),
    .sum_o (add_sum),
    .co_o  (add_co)
  );

  // Two's-complement negate without a carry chain: every bit above the
  // lowest set bit is inverted. Keeps the adder free for the iterations.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    logic [31:0] r;
    logic        seen;
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[i] ^ seen;
      seen = seen | x[i];
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    zdiv_d   = zdiv_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mq_d     = mq_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    add_a    = 32'd0;
    add_b    = 32'd0;
    add_ci   = 1'b0;
    ok       = 1'b0;
    sgn      = ~mdu.op[0];
    sa       = sgn & mdu.a[31];
    sb       = sgn & mdu.b[31];
    mag_a    = sa ? neg32(mdu.a) : mdu.a;
    mag_b    = sb ? neg32(mdu.b) : mdu.b;

    case (state_q)
      S_IDLE: begin
`ifdef MDU_HILO_WRITE_EN
        if (mdu.hi_we) hi_d = mdu.wdata;
        if (mdu.lo_we) lo_d = mdu.wdata;
`endif
        if (mdu.start) begin
          is_div_d = mdu.op[1];
          neg_lo_d = sa ^ sb;
          // Remainder follows the dividend; product high half follows the product.
          neg_hi_d = mdu.op[1] ? sa : (sa ^ sb);
          zdiv_d   = mdu.op[1] & (mdu.b == 32'd0);
          dbz_d    = 1'b0;
          count_d  = 5'd0;
          acc_d    = 32'd0;
          mq_d     = mdu.op[1] ? mag_a : mag_b;
          mcand_d  = mdu.op[1] ? mag_b : mag_a;
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        if (!is_div_q) begin
          add_a  = acc_q;
          add_b  = mq_q[0] ? mcand_q : 32'd0;
          add_ci = 1'b0;
          acc_d  = {add_co, add_sum[31:1]};
          mq_d   = {add_sum[0], mq_q[31:1]};
        end else begin
          add_a  = {acc_q[30:0], mq_q[31]};
          add_b  = ~mcand_q;
          add_ci = 1'b1;
          // The bit shifted out of acc is the 33rd remainder bit; if set the
          // trial subtract cannot borrow.
          ok     = acc_q[31] | add_co;
          acc_d  = ok ? add_sum : add_a;
          mq_d   = {mq_q[30:0], ok};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'(ITER - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        // High half negate: ~hi + carry. For a 64-bit product the carry out
        // of the low half is set only when the low half is zero.
        add_a  = ~acc_q;
        add_b  = 32'd0;
        add_ci = is_div_q ? 1'b1 : (mq_q == 32'd0);
        hi_d   = neg_hi_q ? add_sum : acc_q;
        lo_d   = neg_lo_q ? neg32(mq_q) : mq_q;
        // Divide by zero: the restoring loop already leaves the dividend in
        // the remainder, so only the quotient is forced.
        if (zdiv_q) begin
          lo_d  = 32'hFFFF_FFFF;
          dbz_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      zdiv_q   <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= 32'd0;
      mq_q     <= 32'd0;
      mcand_q  <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      zdiv_q   <= zdiv_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign mdu.busy        = (state_q != S_IDLE);
  assign mdu.done        = done_q;
  assign mdu.div_by_zero = dbz_q;
  assign mdu.hi          = hi_q;
  assign mdu.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_32.sv
// ---------------------------------------------------------------------------
// tb_mul_div_32
// Scoreboard bench for mul_div_32: each issued operation pushes its expected
// hi/lo/div_by_zero (from a 64-bit reference model) and the value is popped
// and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_mul_div_32;

  logic clk;
  logic rst_n;

  mul_div_32_if m ();

  mul_div_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t                 e;
    longint               sa, sbv, p, q, r;
    longint unsigned      ua, ub, up, uq, ur;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    e   = '0;
    case (op)
      2'b00: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; end
        else begin q = sa / sbv; r = sa % sbv; e.hi = r[31:0]; e.lo = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; end
        else begin uq = ua / ub; ur = ua % ub; e.hi = ur[31:0]; e.lo = uq[31:0]; end
      end
    endcase
    return e;
  endfunction

  // Drive start in the current cycle, push the expectation, return #1 after E0
  // with operands scrambled so late changes are exercised.
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    m.start = 1'b1;
    m.op    = op;
    m.a     = a;
    m.b     = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    m.start = 1'b0;
    m.op    = 2'($urandom);
    m.a     = $urandom;
    m.b     = $urandom;
  endtask

  // Count cycles after E0 until done (bounded); also count busy cycles.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (m.done !== 1'b1 && lat < 40) begin
      if (m.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    m.start = 1'b0;
    m.op    = 2'b00;
    m.a     = 32'd0;
    m.b     = 32'd0;
`ifdef MDU_HILO_WRITE_EN
    m.hi_we = 1'b0;
    m.lo_we = 1'b0;
    m.wdata = 32'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (m.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", m.busy); end
    vectors++; if (m.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", m.done); end
    vectors++; if (m.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", m.div_by_zero); end
    vectors++; if (m.hi !== 32'd0 || m.lo !== 32'd0) begin miscompares++; $display("FAIL reset_hilo got %h_%h want 0_0", m.hi, m.lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int   lat, bcnt;
    exp_t e;
    @(negedge clk);
    drive_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    e = sb_q.pop_front();
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL multu_latency got %0d want 33", lat); end
    vectors++; if (bcnt !== 33) begin miscompares++; $display("FAIL multu_busy_cycles got %0d want 33", bcnt); end
    vectors++; if (m.hi !== e.hi || m.lo !== e.lo) begin miscompares++; $display("FAIL multu_result got %h_%h want %h_%h", m.hi, m.lo, e.hi, e.lo); end
    @(posedge clk); #1;
    vectors++; if (m.done !== 1'b0) begin miscompares++; $display("FAIL multu_done_pulse got %b want 0", m.done); end
  endtask

  task automatic test_back_to_back();
    int   lat, bcnt;
    exp_t e;
    @(negedge clk);
    drive_start(2'b00, 32'hFFFF_FFF9, 32'd3);
    wait_done(lat, bcnt);
    e = sb_q.pop_front();
    vectors++; if (m.hi !== e.hi || m.lo !== e.lo) begin miscompares++; $display("FAIL mult_neg_result got %h_%h want %h_%h", m.hi, m.lo, e.hi, e.lo); end
    // Issued in the done cycle.
    drive_start(2'b00, 32'h8000_0000, 32'h8000_0000);
    vectors++; if (m.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept busy got %b want 1", m.busy); end
    wait_done(lat, bcnt);
    e = sb_q.pop_front();
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL b2b_latency got %0d want 33", lat); end
    vectors++; if (m.hi !== e.hi || m.lo !== e.lo) begin miscompares++; $display("FAIL b2b_result got %h_%h want %h_%h", m.hi, m.lo, e.hi, e.lo); end
  endtask

  task automatic test_div();
    int          lat, bcnt;
    exp_t        e;
    logic [1:0]  ops [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    ops = '{2'b10, 2'b11, 2'b10};
    as  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    bs  = '{32'd2, 32'd2, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_start(ops[i], as[i], bs[i]);
      wait_done(lat, bcnt);
      e = sb_q.pop_front();
      vectors++;
      if (m.hi !== e.hi || m.lo !== e.lo || m.div_by_zero !== e.dbz || lat !== 33) begin
        miscompares++;
        $display("FAIL div_%0d got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=33",
                 i, m.hi, m.lo, m.div_by_zero, lat, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int   lat, bcnt;
    exp_t e;
    @(negedge clk);
    drive_start(2'b11, 32'd100, 32'd0);
    wait_done(lat, bcnt);
    e = sb_q.pop_front();
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL dbz_latency got %0d want 33", lat); end
    vectors++; if (m.hi !== e.hi || m.lo !== e.lo || m.div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_u_result got %h_%h dbz=%b want %h_%h dbz=1", m.hi, m.lo, m.div_by_zero, e.hi, e.lo); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (m.div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_hold got %b want 1", m.div_by_zero); end
    drive_start(2'b10, 32'hFFFF_FFFB, 32'd0);
    wait_done(lat, bcnt);
    e = sb_q.pop_front();
    vectors++; if (m.hi !== e.hi || m.lo !== e.lo || m.div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_s_result got %h_%h dbz=%b want %h_%h dbz=1", m.hi, m.lo, m.div_by_zero, e.hi, e.lo); end
    @(negedge clk);
    drive_start(2'b11, 32'd7, 32'd2);
    vectors++; if (m.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_clear got %b want 0", m.div_by_zero); end
    wait_done(lat, bcnt);
    e = sb_q.pop_front();
    vectors++; if (m.hi !== e.hi || m.lo !== e.lo || m.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_after got %h_%h dbz=%b want %h_%h dbz=0", m.hi, m.lo, m.div_by_zero, e.hi, e.lo); end
  endtask

  task automatic test_abort();
    bit seen_done;
    @(negedge clk);
    m.start = 1'b1; m.op = 2'b01; m.a = 32'hFFFF_FFFF; m.b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    m.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    m.start = 1'b1; m.op = 2'b10; m.a = 32'd5; m.b = 32'd0;
    @(posedge clk); #1;
    m.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (m.busy !== 1'b1) begin miscompares++; $display("FAIL abort_prebusy got %b want 1", m.busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if (m.busy !== 1'b0 || m.done !== 1'b0) begin miscompares++; $display("FAIL abort_flags busy=%b done=%b want 0 0", m.busy, m.done); end
    vectors++; if (m.hi !== 32'd0 || m.lo !== 32'd0) begin miscompares++; $display("FAIL abort_hilo got %h_%h want 0_0", m.hi, m.lo); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m.done === 1'b1) seen_done = 1'b1;
    end
    vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got %b want 0", seen_done); end
  endtask

  // Random operations with a stray start pulse mid-flight that must be ignored.
  task automatic test_random_ignore();
    int          lat, bcnt;
    exp_t        e;
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = (i == 5) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
      @(negedge clk);
      drive_start(op, a, b);
      repeat (10) @(posedge clk);
      #1;
      m.start = 1'b1;
      @(posedge clk); #1;
      m.start = 1'b0;
      wait_done(lat, bcnt);
      e = sb_q.pop_front();
      vectors++;
      if (lat + 11 !== 33 || m.hi !== e.hi || m.lo !== e.lo || m.div_by_zero !== e.dbz) begin
        miscompares++;
        $display("FAIL rand_%0d op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=33",
                 i, op, a, b, m.hi, m.lo, m.div_by_zero, lat + 11, e.hi, e.lo, e.dbz);
      end
    end
  endtask

`ifdef MDU_HILO_WRITE_EN
  task automatic test_hilo_write();
    int          lat, bcnt;
    exp_t        e;
    logic [31:0] lo_before;
    @(negedge clk);
    m.hi_we = 1'b1; m.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    m.hi_we = 1'b0;
    vectors++; if (m.hi !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_hi got %h want 12345678", m.hi); end
    lo_before = m.lo;
    drive_start(2'b01, 32'd3, 32'd4);
    m.lo_we = 1'b1; m.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    m.lo_we = 1'b0;
    vectors++; if (m.lo !== lo_before) begin miscompares++; $display("FAIL wr_lo_busy got %h want %h", m.lo, lo_before); end
    wait_done(lat, bcnt);
    e = sb_q.pop_front();
    vectors++; if (m.hi !== e.hi || m.lo !== e.lo) begin miscompares++; $display("FAIL wr_op_result got %h_%h want %h_%h", m.hi, m.lo, e.hi, e.lo); end
    m.lo_we = 1'b1; m.wdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    m.lo_we = 1'b0;
    vectors++; if (m.lo !== 32'h0000_CAFE) begin miscompares++; $display("FAIL wr_lo_done got %h want 0000cafe", m.lo); end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_multu();
    test_back_to_back();
    test_div();
    test_div_by_zero();
    test_abort();
    test_random_ignore();
`ifdef MDU_HILO_WRITE_EN
    test_hilo_write();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
